requant_rshift_pipe: RTL

//  Pipelined signed requantizer: rounding arithmetic right shift of a 32-bit accumulator, then saturation
//  to an OUT_W-bit activation. Counterpart of the left shifter on the scale-up path; sits between the
//  MAC accumulator and the activation writeback buffer. Valid/ready streaming with backpressure.

---
 rtl/requant_rshift_pipe_pkg.sv | 15 +
 rtl/rq_asr_log.sv | 32 +++
 rtl/requant_rshift_pipe.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/requant_rshift_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : requant_rshift_pipe_pkg
// Brief   : Shared widths for the requantizing right-shift pipeline.
// Revision: 1.0
// ============================================================================
package requant_rshift_pipe_pkg;

  localparam int RQ_ACC_W   = 32;
  localparam int RQ_SHIFT_W = 6;
  // One guard bit so the rounding add can never overflow the accumulator range
  localparam int RQ_SUM_W   = 33;

endpackage : requant_rshift_pipe_pkg
`default_nettype wire

// File: rtl/rq_asr_log.sv
`default_nettype none
// ============================================================================
// Module  : rq_asr_log
// Brief   : Combinational 5-stage logarithmic arithmetic right shifter.
// Revision: 1.0
// ============================================================================
module rq_asr_log
  import requant_rshift_pipe_pkg::*;
#(
  parameter int W = RQ_SUM_W
) (
  input  logic [W-1:0] din,
  input  logic [4:0]   shamt,
  output logic [W-1:0] dout
);

  logic [W-1:0] w_stg [0:5];

  assign w_stg[0] = din;

  // Stage i shifts by 16, 8, 4, 2, 1 in turn, filling with the sign bit
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int C_AMT = 1 << (4 - i);
    assign w_stg[i+1] = shamt[4-i]
                      ? {{C_AMT{w_stg[i][W-1]}}, w_stg[i][W-1:C_AMT]}
                      : w_stg[i];
  end

  assign dout = w_stg[5];

endmodule : rq_asr_log
`default_nettype wire

// File: rtl/requant_rshift_pipe.sv
`default_nettype none
// ============================================================================
// Module  : requant_rshift_pipe
// Brief   : 3-stage signed requantizer: round-half-up arithmetic right shift
//           of a 32-bit accumulator, then saturation to OUT_W bits.
// Revision: 1.0
// ============================================================================
module requant_rshift_pipe
  import requant_rshift_pipe_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RQ_ACC_W-1:0]   in_data,
  input  logic [RQ_SHIFT_W-1:0] in_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_sat,
  input  logic                  sat_clr,
  output logic [CNT_W-1:0]      sat_cnt
);

  localparam logic signed [RQ_SUM_W-1:0] C_SAT_MAX =
    {{(RQ_SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RQ_SUM_W-1:0] C_SAT_MIN =
    {{(RQ_SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                r_s1_valid;
  logic [RQ_SUM_W-1:0] r_s1_sum;
  logic [4:0]          r_s1_shamt;
  logic                r_s1_zero;
  logic                r_s2_valid;
  logic [RQ_SUM_W-1:0] r_s2_val;
  logic                r_s2_zero;
  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_sat;
  logic [CNT_W-1:0]    r_sat_cnt;

  logic                w_ld1;
  logic                w_ld2;
  logic                w_ld3;
  logic [RQ_SUM_W-1:0] w_rnd;
  logic [RQ_SUM_W-1:0] w_sum;
  logic [RQ_SUM_W-1:0] w_shifted;
  logic                w_hi;
  logic                w_lo;
  logic [OUT_W-1:0]    w_res;
  logic                w_res_sat;

  // A stage loads when it is empty or its successor is loading this cycle
  assign w_ld3    = !r_out_valid || out_ready;
  assign w_ld2    = !r_s2_valid  || w_ld3;
  assign w_ld1    = !r_s1_valid  || w_ld2;
  assign in_ready = w_ld1;

  always_comb begin
    w_rnd = '0;
    if (!in_shift[5] && (in_shift[4:0] != 5'd0))
      w_rnd = RQ_SUM_W'(1) << (in_shift[4:0] - 5'd1);
  end

  assign w_sum = {in_data[RQ_ACC_W-1], in_data} + w_rnd;

  rq_asr_log #(
    .W     (RQ_SUM_W)
  ) u_asr (
    .din   (r_s1_sum),
    .shamt (r_s1_shamt),
    .dout  (w_shifted)
  );

  assign w_hi = $signed(r_s2_val) > C_SAT_MAX;
  assign w_lo = $signed(r_s2_val) < C_SAT_MIN;

  always_comb begin
    w_res     = r_s2_val[OUT_W-1:0];
    w_res_sat = 1'b0;
    if (r_s2_zero) begin
      w_res = '0;
    end else if (w_hi) begin
      w_res     = C_SAT_MAX[OUT_W-1:0];
      w_res_sat = 1'b1;
    end else if (w_lo) begin
      w_res     = C_SAT_MIN[OUT_W-1:0];
      w_res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sum    <= '0;
      r_s1_shamt  <= '0;
      r_s1_zero   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_val    <= '0;
      r_s2_zero   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      if (w_ld1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_sum   <= w_sum;
          r_s1_shamt <= in_shift[4:0];
          r_s1_zero  <= in_shift[5];
        end
      end
      if (w_ld2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_val  <= w_shifted;
          r_s2_zero <= r_s1_zero;
        end
      end
      if (w_ld3) begin
        r_out_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_out_data <= w_res;
          r_out_sat  <= w_res_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat_cnt <= '0;
    else if (sat_clr)
      r_sat_cnt <= '0;
    else if (r_out_valid && out_ready && r_out_sat && !(&r_sat_cnt))
      r_sat_cnt <= r_sat_cnt + 1'b1;
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign sat_cnt   = r_sat_cnt;

endmodule : requant_rshift_pipe
`default_nettype wire
